// File: rtl/panda_pkg.sv
// -----------------------------------------------------------------------------
// panda_pkg
//
// Purpose: shared definitions for the PANDA data-memory slice. Holds the MMIO
// address map (base plus register offsets), the decode-target enum used by
// panda_dmem, and small helpers for byte-lane merging and MMIO decode.
//
// Contents:
//   DMEM_MMIO_BASE          base byte address of the MMIO window
//   *_OFFSET                byte offsets of the five MMIO registers
//   dmem_target_e           which target a data address selects
//   merge_lanes()           byte-lane write merge
//   decode_mmio()           word address -> MMIO target (or TGT_NONE)
// -----------------------------------------------------------------------------
package panda_pkg;

  localparam logic [31:0] DMEM_MMIO_BASE     = 32'h8000_0000;
  localparam logic [31:0] MTIME_LO_OFFSET    = 32'h0000_0000;
  localparam logic [31:0] MTIME_HI_OFFSET    = 32'h0000_0004;
  localparam logic [31:0] MTIMECMP_LO_OFFSET = 32'h0000_0008;
  localparam logic [31:0] MTIMECMP_HI_OFFSET = 32'h0000_000C;
  localparam logic [31:0] TOHOST_OFFSET      = 32'h0000_0010;

  typedef enum logic [2:0] {
    TGT_RAM,
    TGT_MTIME_LO,
    TGT_MTIME_HI,
    TGT_MTIMECMP_LO,
    TGT_MTIMECMP_HI,
    TGT_TOHOST,
    TGT_NONE
  } dmem_target_e;

  // Replace only the bytes whose lane enable is set; other bytes keep old_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  we);
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        result[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    return result;
  endfunction

  // Decode is done on the word address, so byte-offset bits never matter.
  function automatic dmem_target_e decode_mmio(input logic [29:0] word_addr);
    dmem_target_e tgt;
    logic [31:0]  lo_addr;
    logic [31:0]  hi_addr;
    logic [31:0]  cmp_lo_addr;
    logic [31:0]  cmp_hi_addr;
    logic [31:0]  tohost_addr;
    lo_addr     = DMEM_MMIO_BASE + MTIME_LO_OFFSET;
    hi_addr     = DMEM_MMIO_BASE + MTIME_HI_OFFSET;
    cmp_lo_addr = DMEM_MMIO_BASE + MTIMECMP_LO_OFFSET;
    cmp_hi_addr = DMEM_MMIO_BASE + MTIMECMP_HI_OFFSET;
    tohost_addr = DMEM_MMIO_BASE + TOHOST_OFFSET;
    tgt = TGT_NONE;
    if (word_addr == lo_addr[31:2]) begin
      tgt = TGT_MTIME_LO;
    end else if (word_addr == hi_addr[31:2]) begin
      tgt = TGT_MTIME_HI;
    end else if (word_addr == cmp_lo_addr[31:2]) begin
      tgt = TGT_MTIMECMP_LO;
    end else if (word_addr == cmp_hi_addr[31:2]) begin
      tgt = TGT_MTIMECMP_HI;
    end else if (word_addr == tohost_addr[31:2]) begin
      tgt = TGT_TOHOST;
    end
    return tgt;
  endfunction

endpackage

// File: rtl/panda_dmem_timer.sv
// -----------------------------------------------------------------------------
// panda_dmem_timer
//
// Purpose: 64-bit machine timer. mtime free-runs (+1 per cycle, wrapping),
// mtimecmp is a plain register, and irq is the registered unsigned compare
// mtime >= mtimecmp taken on the values present before each clock edge.
// Both 64-bit registers are written as two 32-bit halves with byte lanes.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   wdata          32-bit write data (already in byte lanes)
//   we             byte-lane write enables (all zero = no write)
//   sel_mtime_lo   access targets mtime[31:0]
//   sel_mtime_hi   access targets mtime[63:32]
//   sel_cmp_lo     access targets mtimecmp[31:0]
//   sel_cmp_hi     access targets mtimecmp[63:32]
//   mtime          current mtime value
//   mtimecmp       current mtimecmp value
//   irq            registered timer interrupt
// -----------------------------------------------------------------------------
module panda_dmem_timer
  import panda_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wdata,
  input  logic [3:0]  we,
  input  logic        sel_mtime_lo,
  input  logic        sel_mtime_hi,
  input  logic        sel_cmp_lo,
  input  logic        sel_cmp_hi,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        irq
);

  logic [63:0] mtime_q;
  logic [63:0] mtime_d;
  logic [63:0] cmp_q;
  logic [63:0] cmp_d;
  logic        irq_q;
  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;

  assign wr_mtime_lo = sel_mtime_lo & (|we);
  assign wr_mtime_hi = sel_mtime_hi & (|we);
  assign wr_cmp_lo   = sel_cmp_lo & (|we);
  assign wr_cmp_hi   = sel_cmp_hi & (|we);

  // A software write to either half of mtime freezes counting for that cycle,
  // so the written value is exactly what is seen next cycle.
  always_comb begin
    mtime_d = mtime_q + 64'd1;
    if (wr_mtime_lo || wr_mtime_hi) begin
      mtime_d = mtime_q;
      if (wr_mtime_lo) begin
        mtime_d[31:0] = merge_lanes(mtime_q[31:0], wdata, we);
      end
      if (wr_mtime_hi) begin
        mtime_d[63:32] = merge_lanes(mtime_q[63:32], wdata, we);
      end
    end
  end

  always_comb begin
    cmp_d = cmp_q;
    if (wr_cmp_lo) begin
      cmp_d[31:0] = merge_lanes(cmp_q[31:0], wdata, we);
    end
    if (wr_cmp_hi) begin
      cmp_d[63:32] = merge_lanes(cmp_q[63:32], wdata, we);
    end
  end

  // Reset dominates, so any write presented during reset is dropped.
  // irq compares the pre-edge registers, which gives the one-cycle lag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q <= 64'd0;
      cmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
      irq_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      irq_q   <= (mtime_q >= cmp_q);
    end
  end

  assign mtime    = mtime_q;
  assign mtimecmp = cmp_q;
  assign irq      = irq_q;

endmodule

// File: rtl/panda_dmem.sv
// -----------------------------------------------------------------------------
// panda_dmem
//
// Purpose: data-side memory for the PANDA core. Decodes the byte address into
// a DEPTH x 32 RAM at address zero or one of five MMIO registers (timer and
// TOHOST). Reads are combinational; writes commit per byte lane on the rising
// clock edge. Unmapped addresses raise access_fault_o, read as zero and
// discard writes.
//
// Parameters:
//   DEPTH           RAM size in 32-bit words (power of two, >= 16)
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           asynchronous active-high reset (RAM is not reset)
//   data_addr_i     byte address
//   data_wdata_i    write data in byte lanes
//   data_we_i       byte-lane write enables, 4'b0000 = read
//   data_rdata_o    combinational read data for the addressed word
//   access_fault_o  address selects no target
//   timer_irq_o     registered mtime >= mtimecmp
//   tohost_valid_o  one-cycle pulse after each TOHOST write
//   tohost_data_o   last value written to TOHOST
// -----------------------------------------------------------------------------
module panda_dmem
  import panda_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_we_i,
  output logic [31:0] data_rdata_o,
  output logic        access_fault_o,
  output logic        timer_irq_o,
  output logic        tohost_valid_o,
  output logic [31:0] tohost_data_o
);

  localparam int AW = $clog2(DEPTH);

  dmem_target_e  target;
  logic [AW-1:0] ram_idx;
  logic [3:0]    ram_we;
  logic          tohost_wr;
  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;
  logic          tohost_valid_q;
  logic [31:0]   tohost_data_q;
  logic          unused_addr_bits;

  // Zero at time 0 so simulation never reads X from unwritten words.
  logic [31:0]   mem [DEPTH] = '{default: 32'h0};

  assign unused_addr_bits = ^data_addr_i[1:0];
  assign ram_idx          = data_addr_i[AW+1:2];

  // RAM occupies the bottom DEPTH*4 bytes: every address bit above the RAM
  // index must be zero. Anything else falls through to the MMIO decoder.
  always_comb begin
    target = TGT_NONE;
    if (data_addr_i[31:AW+2] == '0) begin
      target = TGT_RAM;
    end else begin
      target = decode_mmio(data_addr_i[31:2]);
    end
  end

  assign ram_we         = (target == TGT_RAM) ? data_we_i : 4'b0000;
  assign tohost_wr      = (target == TGT_TOHOST) && (|data_we_i);
  assign access_fault_o = (target == TGT_NONE);

  // RAM with per-lane write; deliberately outside the reset domain.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we[i]) begin
        mem[ram_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
      end
    end
  end

  panda_dmem_timer u_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wdata        (data_wdata_i),
    .we           (data_we_i),
    .sel_mtime_lo (target == TGT_MTIME_LO),
    .sel_mtime_hi (target == TGT_MTIME_HI),
    .sel_cmp_lo   (target == TGT_MTIMECMP_LO),
    .sel_cmp_hi   (target == TGT_MTIMECMP_HI),
    .mtime        (mtime),
    .mtimecmp     (mtimecmp),
    .irq          (timer_irq_o)
  );

  // TOHOST: lanes merge into the held value, and the valid pulse is simply the
  // registered write strobe, so consecutive writes give consecutive pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= 32'h0;
    end else begin
      tohost_valid_q <= tohost_wr;
      if (tohost_wr) begin
        tohost_data_q <= merge_lanes(tohost_data_q, data_wdata_i, data_we_i);
      end
    end
  end

  assign tohost_valid_o = tohost_valid_q;
  assign tohost_data_o  = tohost_data_q;

  // Combinational read mux; registers show their pre-edge value, so a
  // same-cycle write is only visible from the next cycle.
  always_comb begin
    data_rdata_o = 32'h0;
    case (target)
      TGT_RAM:         data_rdata_o = mem[ram_idx];
      TGT_MTIME_LO:    data_rdata_o = mtime[31:0];
      TGT_MTIME_HI:    data_rdata_o = mtime[63:32];
      TGT_MTIMECMP_LO: data_rdata_o = mtimecmp[31:0];
      TGT_MTIMECMP_HI: data_rdata_o = mtimecmp[63:32];
      TGT_TOHOST:      data_rdata_o = tohost_data_q;
      default:         data_rdata_o = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_panda_dmem.sv
// -----------------------------------------------------------------------------
// tb_panda_dmem
//
// Purpose: self-checking bench for panda_dmem. Inputs change on the falling
// clock edge and outputs are sampled 1 ns later, so each step observes the
// state left by the previous rising edge. A vector table covers RAM and
// decode behaviour; hand-written sequences cover reset, the timer and TOHOST.
// -----------------------------------------------------------------------------
module tb_panda_dmem;

  localparam logic [31:0] A_MTIME_LO  = 32'h8000_0000;
  localparam logic [31:0] A_MTIME_HI  = 32'h8000_0004;
  localparam logic [31:0] A_CMP_LO    = 32'h8000_0008;
  localparam logic [31:0] A_CMP_HI    = 32'h8000_000C;
  localparam logic [31:0] A_TOHOST    = 32'h8000_0010;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [31:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  localparam int NVEC = 20;

  logic        clk;
  logic        rst;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_we;
  logic [31:0] data_rdata;
  logic        access_fault;
  logic        timer_irq;
  logic        tohost_valid;
  logic [31:0] tohost_data;

  int total;
  int bad;
  vec_t vecs [NVEC];

  panda_dmem #(.DEPTH(1024)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_we_i      (data_we),
    .data_rdata_o   (data_rdata),
    .access_fault_o (access_fault),
    .timer_irq_o    (timer_irq),
    .tohost_valid_o (tohost_valid),
    .tohost_data_o  (tohost_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one access at the falling edge; it commits at the next rising edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] we);
    @(negedge clk);
    data_addr  = addr;
    data_wdata = wdata;
    data_we    = we;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] w,
                              input logic [3:0] we, input logic [31:0] r,
                              input logic f);
    vec_t v;
    v.addr = a; v.wdata = w; v.we = we; v.exp_rdata = r; v.exp_fault = f;
    return v;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;

    // RAM / decode vectors; expected read is the pre-write value of the cycle.
    vecs[0]  = mk(32'h0000_0010, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0);
    vecs[1]  = mk(32'h0000_0012, 32'h00AA_0000, 4'h4, 32'h1122_3344, 1'b0);
    vecs[2]  = mk(32'h0000_0010, 32'h0,         4'h0, 32'h11AA_3344, 1'b0);
    vecs[3]  = mk(32'h0000_0013, 32'h0,         4'h0, 32'h11AA_3344, 1'b0);
    vecs[4]  = mk(32'h4000_0000, 32'h0,         4'h0, 32'h0000_0000, 1'b1);
    vecs[5]  = mk(32'h4000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b1);
    vecs[6]  = mk(32'h4000_0000, 32'h0,         4'h0, 32'h0000_0000, 1'b1);
    vecs[7]  = mk(32'h0000_0010, 32'h0,         4'h0, 32'h11AA_3344, 1'b0);
    vecs[8]  = mk(32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0);
    vecs[9]  = mk(32'h0000_0FFC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0);
    vecs[10] = mk(32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b1);
    vecs[11] = mk(32'h0000_0000, 32'h0,         4'h0, 32'h0000_0000, 1'b0);
    vecs[12] = mk(32'h8000_0014, 32'h0,         4'h0, 32'h0000_0000, 1'b1);
    vecs[13] = mk(A_CMP_LO,      32'h0,         4'h0, 32'hFFFF_FFFF, 1'b0);
    vecs[14] = mk(32'h8000_000E, 32'h0,         4'h0, 32'hFFFF_FFFF, 1'b0);
    vecs[15] = mk(A_CMP_LO,      32'h0000_0014, 4'h1, 32'hFFFF_FFFF, 1'b0);
    vecs[16] = mk(A_CMP_LO,      32'h0,         4'h0, 32'hFFFF_FF14, 1'b0);
    vecs[17] = mk(32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0000_0000, 1'b1);
    vecs[18] = mk(32'h0000_0020, 32'hA5A5_A5A5, 4'h9, 32'h0000_0000, 1'b0);
    vecs[19] = mk(32'h0000_0020, 32'h0,         4'h0, 32'hA500_00A5, 1'b0);

    // Reset with a TOHOST write pending: the write must be discarded.
    rst        = 1'b1;
    data_addr  = A_TOHOST;
    data_wdata = 32'h0000_0055;
    data_we    = 4'hF;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_irq", {31'b0, timer_irq}, 32'd0);
    checkOutput("rst_valid", {31'b0, tohost_valid}, 32'd0);
    checkOutput("rst_tohost", tohost_data, 32'h0);
    rst = 1'b0;
    applyStimulus(A_MTIME_LO, 32'h0, 4'h0);
    checkOutput("mtime_first", data_rdata, 32'd0);
    applyStimulus(A_MTIME_LO, 32'h0, 4'h0);
    checkOutput("mtime_second", data_rdata, 32'd1);
    checkOutput("tohost_after_rst", tohost_data, 32'h0);
    checkOutput("valid_after_rst", {31'b0, tohost_valid}, 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].we);
      checkOutput($sformatf("vec%0d_rdata", i), data_rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_fault", i), {31'b0, access_fault},
                  {31'b0, vecs[i].exp_fault});
    end

    // Carry from LO into HI, then wrap of the full 64-bit counter.
    applyStimulus(A_MTIME_LO, 32'hFFFF_FFFE, 4'hF);
    applyStimulus(A_MTIME_HI, 32'h0000_0000, 4'hF);
    applyStimulus(A_MTIME_LO, 32'h0, 4'h0);
    checkOutput("carry_lo0", data_rdata, 32'hFFFF_FFFE);
    applyStimulus(A_MTIME_LO, 32'h0, 4'h0);
    checkOutput("carry_lo1", data_rdata, 32'hFFFF_FFFF);
    applyStimulus(A_MTIME_LO, 32'h0, 4'h0);
    checkOutput("carry_lo2", data_rdata, 32'h0000_0000);
    applyStimulus(A_MTIME_HI, 32'h0, 4'h0);
    checkOutput("carry_hi", data_rdata, 32'h0000_0001);
    applyStimulus(A_MTIME_LO, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(A_MTIME_HI, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(A_MTIME_HI, 32'h0, 4'h0);
    checkOutput("wrap_pre_hi", data_rdata, 32'hFFFF_FFFF);
    applyStimulus(A_MTIME_LO, 32'h0, 4'h0);
    checkOutput("wrap_lo", data_rdata, 32'h0000_0000);
    applyStimulus(A_MTIME_HI, 32'h0, 4'h0);
    checkOutput("wrap_hi", data_rdata, 32'h0000_0000);

    // Compare: reset, then mtimecmp = 20.
    @(negedge clk);
    rst = 1'b1;
    data_we = 4'h0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(A_CMP_LO, 32'd20, 4'hF);
    applyStimulus(A_CMP_HI, 32'd0, 4'hF);
    for (int k = 0; k < 23; k++) begin
      int exp_m;
      exp_m = 2 + k;
      applyStimulus(A_MTIME_LO, 32'h0, 4'h0);
      checkOutput($sformatf("cmp_mtime%0d", exp_m), data_rdata, exp_m);
      checkOutput($sformatf("cmp_irq%0d", exp_m), {31'b0, timer_irq},
                  (exp_m >= 21) ? 32'd1 : 32'd0);
    end
    applyStimulus(A_CMP_HI, 32'd1, 4'hF);
    checkOutput("raise_irq25", {31'b0, timer_irq}, 32'd1);
    applyStimulus(A_CMP_LO, 32'd0, 4'hF);
    checkOutput("raise_irq26", {31'b0, timer_irq}, 32'd1);
    applyStimulus(A_MTIME_LO, 32'h0, 4'h0);
    checkOutput("raise_mtime27", data_rdata, 32'd27);
    checkOutput("raise_irq27", {31'b0, timer_irq}, 32'd0);
    applyStimulus(A_CMP_HI, 32'h0, 4'h0);
    checkOutput("cmp_hi_read", data_rdata, 32'd1);

    // TOHOST: word then halfword write give back-to-back pulses.
    applyStimulus(A_TOHOST, 32'h0000_0001, 4'hF);
    checkOutput("th_valid0", {31'b0, tohost_valid}, 32'd0);
    applyStimulus(A_TOHOST, 32'h0000_BEEF, 4'h3);
    checkOutput("th_valid1", {31'b0, tohost_valid}, 32'd1);
    checkOutput("th_data1", tohost_data, 32'h0000_0001);
    applyStimulus(A_TOHOST, 32'hFFFF_FFFF, 4'h0);
    checkOutput("th_valid2", {31'b0, tohost_valid}, 32'd1);
    checkOutput("th_data2", tohost_data, 32'h0000_BEEF);
    checkOutput("th_rdata2", data_rdata, 32'h0000_BEEF);
    applyStimulus(A_TOHOST, 32'h0, 4'h0);
    checkOutput("th_valid3", {31'b0, tohost_valid}, 32'd0);
    checkOutput("th_data3", tohost_data, 32'h0000_BEEF);

    // Mid-operation reset with mtime = 500 and the interrupt asserted.
    applyStimulus(A_CMP_HI, 32'd0, 4'hF);
    applyStimulus(A_MTIME_LO, 32'd500, 4'hF);
    applyStimulus(A_MTIME_LO, 32'h0, 4'h0);
    checkOutput("mid_mtime", data_rdata, 32'd500);
    checkOutput("mid_irq", {31'b0, timer_irq}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_mtime", data_rdata, 32'd0);
    checkOutput("mid_rst_irq", {31'b0, timer_irq}, 32'd0);
    checkOutput("mid_rst_tohost", tohost_data, 32'h0);
    data_addr = 32'h0000_0010;
    #1;
    checkOutput("mid_rst_ram", data_rdata, 32'h11AA_3344);
    @(posedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(A_CMP_LO, 32'h0, 4'h0);
    checkOutput("post_rst_cmp", data_rdata, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/panda_dmem.md
PANDA_DMEM -- requirements
Module: panda_dmem

Interface
REQ-001 Parameter DEPTH, default 1024, sets the data RAM size in 32-bit words; it SHALL be a power of two of at least 16.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset; asynchronous, active-high.
REQ-004 data_addr_i  input  32  byte address from the core datapath.
REQ-005 data_wdata_i  input  32  write data, already shifted into byte lanes.
REQ-006 data_we_i  input  4  byte-lane write enables; 4'b0000 means a read.
REQ-007 data_rdata_o  output  32  read data for the whole word at data_addr_i[31:2].
REQ-008 access_fault_o  output  1  the current address decodes to no target.
REQ-009 timer_irq_o  output  1  machine timer interrupt, registered.
REQ-010 tohost_valid_o  output  1  one-cycle pulse per TOHOST write.
REQ-011 tohost_data_o  output  32  last value written to TOHOST.

Function
REQ-012 Address map: RAM 0x0000_0000 to DEPTH*4-1; MTIME_LO 0x8000_0000; MTIME_HI 0x8000_0004; MTIMECMP_LO 0x8000_0008; MTIMECMP_HI 0x8000_000C; TOHOST 0x8000_0010; address bits [1:0] are ignored for decode.
REQ-013 Reads SHALL be combinational with zero-cycle latency, so that data_rdata_o is valid in the same cycle as data_addr_i.
REQ-014 Writes SHALL commit at the rising edge for each lane i with data_we_i[i]=1; unselected lanes SHALL keep their values.
REQ-015 A read of an address written in the same cycle SHALL return the old value; the new value SHALL appear from the next cycle.
REQ-016 For an unmapped address, access_fault_o=1 combinationally, data_rdata_o=0, and any write SHALL be discarded.
REQ-017 mtime is 64 bits and SHALL increment by 1 every cycle; the carry from LO SHALL propagate into HI in the same cycle.
REQ-018 The increment SHALL wrap from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-019 In a cycle that writes MTIME_LO or MTIME_HI, the written lanes SHALL take the written data, the unwritten lanes SHALL hold, and mtime SHALL NOT increment in that cycle.
REQ-020 MTIMECMP_LO and MTIMECMP_HI SHALL be writable per byte lane and SHALL NOT count.
REQ-021 timer_irq_o SHALL be registered as (mtime >= mtimecmp), unsigned 64-bit, evaluated on the pre-edge values; the response therefore lags by one cycle.
REQ-022 A TOHOST write with any lane enabled SHALL merge the enabled lanes into tohost_data_o and assert tohost_valid_o for exactly the next cycle.
REQ-023 Back-to-back TOHOST writes SHALL produce back-to-back pulses.
REQ-024 TOHOST reads SHALL return tohost_data_o and SHALL NOT pulse tohost_valid_o.

Reset
REQ-025 rst_i SHALL immediately force: mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, timer_irq_o=0, tohost_valid_o=0, tohost_data_o=0.
REQ-026 RAM contents SHALL NOT be affected by reset; RAM SHALL be zero-initialised at time 0 in simulation.
REQ-027 A write presented while rst_i=1 SHALL be discarded for all MMIO targets; RAM writes under reset are don't-care.
REQ-028 After rst_i deasserts, mtime SHALL read 0 in the first cycle and 1 in the second.

Structure
REQ-029 The address-map constants (DMEM_MMIO_BASE and the five register offsets) SHALL be defined in panda_pkg.
REQ-030 The 64-bit mtime/mtimecmp/irq logic SHALL be a sub-module, panda_dmem_timer, instantiated once.
REQ-031 RAM SHALL be inferred as a DEPTH x 32 array with per-lane write.

Verification
REQ-032 Word then byte write: SW 0x11223344 @0x10, then SB lane2 (we=4'b0100, wdata=0x00AA0000) @0x12 -> read @0x10 returns 0x11AA3344.
REQ-033 Unmapped access: read @0x4000_0000 -> access_fault_o=1, data_rdata_o=0; write 0xDEADBEEF there, then read back -> still 0 and RAM unchanged.
REQ-034 Carry and wrap: write MTIME_LO=0xFFFF_FFFE, MTIME_HI=0 -> two cycles later HI=1 and LO=0; write MTIME_HI=0xFFFF_FFFF with LO=0xFFFF_FFFF -> next cycle mtime=0.
REQ-035 Compare: mtimecmp=20 after reset -> timer_irq_o rises exactly one cycle after mtime reaches 20; raising mtimecmp to 0x1_0000_0000 -> timer_irq_o drops the following cycle.
REQ-036 TOHOST: SW 0x1 then SH 0xBEEF lanes[1:0] -> two consecutive single-cycle pulses with tohost_data_o=0x0000_0001 then 0x0000_BEEF.
REQ-037 Reset mid-operation: assert rst_i between clock edges while mtime=500 and timer_irq_o=1 -> both go to 0 immediately, and a RAM word written before reset still reads back.
